// File: rtl/mult_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_ctrl
// Purpose  : Two-port round-robin arbiter and clear/load/compute sequencer
//            for a single shared sequential signed multiplier core.
// Revision : 1.0
// ============================================================================
module mult_share_ctrl #(
  parameter int WIDTH       = 32,
  parameter int LOAD_CYCLES = 2,
  parameter int CALC_CYCLES = 33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               resp_valid,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_prod,
  output logic               busy,
  output logic               mul_rst,
  output logic               mul_en,
  output logic               mul_load,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_out
);

  localparam int c_cnt_max = (LOAD_CYCLES > CALC_CYCLES) ? LOAD_CYCLES : CALC_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_load_init = c_cnt_w'(LOAD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_calc_init = c_cnt_w'(CALC_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_zero  = '0;

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_clear = 3'd1;
  localparam logic [2:0] c_st_load  = 3'd2;
  localparam logic [2:0] c_st_run   = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic               r_cur_id;
  logic               r_last_id;
  logic [2*WIDTH-1:0] r_resp_prod;
  logic               r_resp_id;
  logic               r_rst_hold;
  logic               w_grant1;
  logic               w_accept;
  logic               w_cnt_zero;
  logic               w_idle;

  // Requester 1 wins when it is the only one asking, or on a tie when 0 went last.
  assign w_grant1   = req1_valid & (~req0_valid | ~r_last_id);
  assign w_idle     = (r_state == c_st_idle);
  assign w_accept   = w_idle & (req0_valid | req1_valid);
  assign w_cnt_zero = (r_cnt == c_cnt_zero);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (w_accept) w_next_state = c_st_clear;
      c_st_clear: w_next_state = c_st_load;
      c_st_load:  if (w_cnt_zero) w_next_state = c_st_run;
      c_st_run:   if (w_cnt_zero) w_next_state = c_st_done;
      c_st_done:  w_next_state = c_st_idle;
      default:    w_next_state = c_st_idle;
    endcase
  end

  // Output logic; r_rst_hold keeps the core in reset until the first clock after rst
  always_comb begin
    busy       = ~w_idle;
    mul_rst    = r_rst_hold | (r_state == c_st_clear);
    mul_en     = (r_state == c_st_load) | (r_state == c_st_run);
    mul_load   = (r_state == c_st_load);
    resp_valid = (r_state == c_st_done);
    req0_ready = w_idle & ~w_grant1;
    req1_ready = w_idle & w_grant1;
  end

  // Datapath: phase counter, operand latch, arbitration history, result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= c_cnt_zero;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_cur_id    <= 1'b0;
      r_last_id   <= 1'b1;
      r_resp_prod <= '0;
      r_resp_id   <= 1'b0;
      r_rst_hold  <= 1'b1;
    end else begin
      r_rst_hold <= 1'b0;
      case (r_state)
        c_st_clear: r_cnt <= c_load_init;
        c_st_load:  r_cnt <= w_cnt_zero ? c_calc_init : (r_cnt - c_cnt_one);
        c_st_run:   if (!w_cnt_zero) r_cnt <= r_cnt - c_cnt_one;
        default:    r_cnt <= r_cnt;
      endcase
      if (w_accept) begin
        r_op_a    <= w_grant1 ? req1_a : req0_a;
        r_op_b    <= w_grant1 ? req1_b : req0_b;
        r_cur_id  <= w_grant1;
        r_last_id <= w_grant1;
      end
      if ((r_state == c_st_run) && w_cnt_zero) begin
        r_resp_prod <= mul_out;
        r_resp_id   <= r_cur_id;
      end
    end
  end

  assign mul_a     = r_op_a;
  assign mul_b     = r_op_b;
  assign resp_prod = r_resp_prod;
  assign resp_id   = r_resp_id;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_ctrl
// Purpose  : Self-checking bench for mult_share_ctrl with a behavioural
//            sequential multiplier core and a response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_mult_share_ctrl;

  localparam int c_calc = 33;
  localparam int c_lat  = 37;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready, resp_valid, resp_id, busy;
  logic        mul_rst, mul_en, mul_load;
  logic [31:0] mul_a, mul_b;
  logic [63:0] resp_prod, mul_out;

  mult_share_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_prod(resp_prod), .busy(busy),
    .mul_rst(mul_rst), .mul_en(mul_en), .mul_load(mul_load),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out)
  );

  always #5 clk = ~clk;

  // Core model: product is only presented during the last compute cycle
  logic signed [31:0] r_ca, r_cb;
  int                 r_ccnt;
  always @(posedge clk) begin
    if (mul_rst) begin
      r_ca <= '0; r_cb <= '0; r_ccnt <= 0;
    end else if (mul_en && mul_load) begin
      r_ca <= mul_a; r_cb <= mul_b; r_ccnt <= 0;
    end else if (mul_en) begin
      r_ccnt <= r_ccnt + 1;
    end
  end
  assign mul_out = (r_ccnt == c_calc - 1) ? (64'(r_ca) * 64'(r_cb)) : 64'hA5A5_5A5A_0F0F_F0F0;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  exp_t        sb[$];
  int          grants[$];
  int          resp_cyc[$];
  int          total = 0, bad = 0;
  int          cyc = 0, nresp = 0;
  int          acc0 = 0, acc1 = 0;
  int          n_rst = 0, n_load = 0;
  bit          stab_bad = 0;
  logic [63:0] got_prod;
  logic        got_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h need %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_acc(input logic id, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.id   = id;
    e.a    = a;
    e.b    = b;
    e.prod = 64'($signed(a)) * 64'($signed(b));
    e.cyc  = cyc;
    sb.push_back(e);
    grants.push_back(int'(id));
    n_rst = 0; n_load = 0; stab_bad = 0;
    chk("ready_exclusive", 64'(req0_ready & req1_ready), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor / scoreboard, sampling on the falling edge
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (busy && sb.size() > 0) begin
        if (mul_rst) n_rst++;
        if (mul_load) n_load++;
        if (mul_a !== sb[0].a || mul_b !== sb[0].b) stab_bad = 1;
      end
      if (resp_valid) begin
        nresp++;
        resp_cyc.push_back(cyc);
        got_prod = resp_prod;
        got_id   = resp_id;
        chk("ready_low_in_done", {62'd0, req0_ready, req1_ready}, 64'd0);
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_resp: got resp id=%0d prod=%0h need none", resp_id, resp_prod);
        end else begin
          e = sb.pop_front();
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_prod", resp_prod, e.prod);
          chk("latency", 64'(cyc - e.cyc), 64'(c_lat));
          chk("clear_cycles", 64'(n_rst), 64'd1);
          chk("load_cycles", 64'(n_load), 64'd2);
          chk("operand_stable", 64'(stab_bad), 64'd0);
        end
      end
      if (req0_valid && req0_ready) begin acc0++; push_acc(1'b0, req0_a, req0_b); end
      if (req1_valid && req1_ready) begin acc1++; push_acc(1'b1, req1_a, req1_b); end
    end
  end

  task automatic wait_acc(input logic id, input int target);
    int n = 0;
    while (((id ? acc1 : acc0) < target) && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("accept_timeout", 64'((id ? acc1 : acc0) >= target), 64'd1);
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (nresp < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("resp_timeout", 64'(nresp >= target), 64'd1);
  endtask

  // Single request; operands are scrambled right after acceptance
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b);
    int tgt;
    @(posedge clk); #1;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; tgt = acc1 + 1; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; tgt = acc0 + 1; end
    wait_acc(id, tgt);
    #1;
    if (id) begin req1_valid = 0; req1_a = $urandom; req1_b = $urandom; end
    else    begin req0_valid = 0; req0_a = $urandom; req0_b = $urandom; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_mul_en_load"}, {62'd0, mul_en, mul_load}, 64'd0);
    chk({tag, "_mul_rst"}, 64'(mul_rst), 64'd1);
    chk({tag, "_mul_ab"}, {mul_a, mul_b}, 64'd0);
    chk({tag, "_resp_prod"}, resp_prod, 64'd0);
    chk({tag, "_resp_id"}, 64'(resp_id), 64'd0);
  endtask

  initial begin
    vec_t tv[6];
    int   base;
    tv[0] = '{1'b0, 32'd12,         32'hFFFF_FFE0, 64'hFFFF_FFFF_FFFF_FE80};
    tv[1] = '{1'b1, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
    tv[2] = '{1'b0, 32'd13,         32'd20,        64'd260};
    tv[3] = '{1'b1, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    tv[4] = '{1'b0, 32'hFFFF_FFFF,  32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001};
    tv[5] = '{1'b1, 32'd0,          32'd1234,      64'd0};

    // Power-on reset
    #22;
    check_reset_outputs("por");
    chk("por_ready0", 64'(req0_ready), 64'd1);
    rst = 0;
    @(posedge clk); #1;
    chk("mul_rst_release", 64'(mul_rst), 64'd0);

    // Table of single operations
    for (int i = 0; i < 6; i++) begin
      base = nresp;
      issue(tv[i].id, tv[i].a, tv[i].b);
      wait_resp(base + 1);
      chk("tbl_prod", got_prod, tv[i].prod);
      chk("tbl_id", 64'(got_id), 64'(tv[i].id));
    end

    // Both valid from reset release: req0 first, then req1, 38 cycles apart
    @(posedge clk); #1;
    rst = 1;
    req0_valid = 1; req0_a = 32'hFFFF_FFCD; req0_b = 32'hFFFF_FFFC;
    req1_valid = 1; req1_a = 32'hFFFF_FFE7; req1_b = 32'hFFFF_FFC4;
    sb.delete(); grants.delete(); resp_cyc.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    base = nresp;
    wait_acc(1'b0, acc0 + 1);
    #1 req0_valid = 0;
    wait_acc(1'b1, acc1 + 1);
    #1 req1_valid = 0;
    wait_resp(base + 2);
    chk("tie_first", 64'(grants[0]), 64'd0);
    chk("tie_second", 64'(grants[1]), 64'd1);
    chk("tie_last_prod", got_prod, 64'd1500);
    chk("pulse_spacing", 64'(resp_cyc[1] - resp_cyc[0]), 64'd38);
    repeat (40) @(posedge clk);
    chk("two_pulses_only", 64'(nresp - base), 64'd2);

    // Continuous contention: grants must alternate
    grants.delete();
    base = nresp;
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 32'd7;         req0_b = 32'd9;
    req1_valid = 1; req1_a = 32'hFFFF_FFFD; req1_b = 32'd11;
    wait_resp(base + 6);
    #1 req0_valid = 0; req1_valid = 0;
    for (int k = 0; k < 6; k++) begin
      if (k < grants.size()) chk("alternate_grant", 64'(grants[k]), 64'(k % 2));
      else chk("alternate_missing", 64'(grants.size()), 64'(k + 1));
    end

    // Reset during RUN cycle 10 of 5*15
    base = nresp;
    issue(1'b0, 32'd5, 32'd15);
    repeat (12) @(posedge clk);
    #1 rst = 1;
    #1;
    check_reset_outputs("abort");
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("abort_mul_rst_release", 64'(mul_rst), 64'd0);
    repeat (40) @(posedge clk);
    chk("abort_no_resp", 64'(nresp - base), 64'd0);
    issue(1'b1, 32'd0, 32'd1234);
    wait_resp(base + 1);
    chk("after_abort_prod", got_prod, 64'd0);
    chk("after_abort_id", 64'(got_id), 64'd1);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish need finish by 200000ns");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencing controller and two-port round-robin arbiter for the team's shared sequential signed multiplier core (clock, reset, enable, load, A, B, product). It accepts operand pairs from two requesters over valid/ready handshakes and drives the core through clear, load and compute phases. It captures the product after a fixed cycle count and returns it with the requester ID. The block sits between the requesting datapaths and a single multiplier instance, so that instance is never driven by more than one source.

## Interface
- WIDTH, 32, operand width; product width is 2*WIDTH
- LOAD_CYCLES, 2, cycles mul_load is held high (1..15)
- CALC_CYCLES, 33, cycles of compute with mul_en high and mul_load low before the product is valid (1..63)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a, req0_b  in  WIDTH  requester 0 signed operands
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0
- resp_valid  out  1  one-cycle pulse, product available
- resp_id  out  1  requester that owns resp_prod
- resp_prod  out  2*WIDTH  signed product
- busy  out  1  high in any state other than IDLE
- mul_rst  out  1  drives the core reset
- mul_en  out  1  drives the core enable
- mul_load  out  1  drives the core load
- mul_a, mul_b  out  WIDTH  drive the core operands
- mul_out  in  2*WIDTH  core product

## Operation
- FSM states: IDLE, CLEAR, LOAD, RUN, DONE. A single down-counter, sized for max(LOAD_CYCLES, CALC_CYCLES), times LOAD and RUN.
- IDLE: req*_ready is high only for the granted requester. Grant is combinational from the valid inputs and the last_id register:
  - only one valid: that requester is granted.
  - both valid: the requester != last_id is granted.
  - after reset, last_id=1, so req0 wins the first tie.
- Acceptance (valid&ready): latch the operands into op_a and op_b, latch the ID into cur_id, set last_id=cur_id, go to CLEAR.
- CLEAR, 1 cycle: mul_rst=1, mul_en=0, mul_load=0.
- LOAD, LOAD_CYCLES cycles: mul_rst=0, mul_en=1, mul_load=1.
- RUN, CALC_CYCLES cycles: mul_en=1, mul_load=0. On the edge that ends the last RUN cycle, capture mul_out into resp_prod and cur_id into resp_id.
- DONE, 1 cycle: resp_valid=1, then go to IDLE. req*_ready is low in DONE.
- mul_a and mul_b are driven from op_a and op_b. They are constant from CLEAR through DONE.
- The arbiter checks neither the sign nor the width of the product. resp_prod is the core output bit-for-bit.
- No requester queueing. A non-granted requester keeps valid high and must hold its operands stable until accepted.
- resp_prod and resp_id hold their last value until the next capture.

## Timing
- Reset values (asynchronous):
  - state=IDLE, last_id=1.
  - op_a, op_b, mul_a, mul_b = 0; resp_prod=0, resp_id=0.
  - resp_valid=0, busy=0, mul_en=0, mul_load=0.
  - mul_rst=1 while rst is high. mul_rst is 0 from the first clock after rst deasserts.
- Reset mid-operation aborts immediately. No response is issued and the aborted request is lost. The next grant follows the reset tie rule (req0 first).
- Latency: acceptance in cycle T gives CLEAR at T+1, LOAD at T+2..T+1+LOAD_CYCLES, RUN for CALC_CYCLES cycles, and resp_valid at T+2+LOAD_CYCLES+CALC_CYCLES. With defaults, resp_valid is at T+37.
- Throughput: the next acceptance is no earlier than the cycle after DONE. With defaults, one operation per 38 cycles.
- req*_ready may be high in IDLE whether or not valid is high. It is never high for both requesters in the same cycle.
- A valid that rises during a busy period is served in the first IDLE cycle, subject to the tie rule.

## Test plan
- req0 with a=12, b=-32, req1 idle. Required:
  - req0_ready=1 at the accept cycle.
  - mul_rst high for exactly 1 cycle, then mul_load high for 2 cycles.
  - resp_valid pulses 37 cycles after acceptance with resp_prod=-384 and resp_id=0.
- req0 (-51, -4) and req1 (-25, -60) both valid from reset release. Required:
  - req0 served first, giving 204 with id 0.
  - req1 served next, giving 1500 with id 1.
  - exactly two resp_valid pulses, 38 cycles apart.
- Both requesters continuously valid for 6 operations. Required: grants alternate 0,1,0,1,0,1 and each resp_id matches its grant.
- rst asserted at RUN cycle 10 of a 5*15 operation. Required:
  - all outputs return to reset values immediately.
  - no resp_valid for the aborted operation.
  - a following 0*1234 request on req1 completes with resp_prod=0 and id 1.
- Extreme operands on req1: a=b=-2^31. Required: resp_prod=2^62.
- Operands changed on req0 one cycle after acceptance. Required: mul_a and mul_b stay at the latched values and the response reflects the original pair (13*20=260).
